// File: rtl/seq_instr_loader.sv
// Loads DRRA per-cell sequencer instruction memories from a 32-bit header/instruction
// word stream and issues per-cell sequencer start pulses.
module seq_instr_loader #(
  parameter int unsigned ROWS        = 2,
  parameter int unsigned COLUMNS     = 8,
  parameter int unsigned INSTR_WIDTH = 27,
  parameter int unsigned INSTR_DEPTH = 64,
  parameter int unsigned ADDR_WIDTH  = 6,
  localparam int unsigned ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned COL_W      = (COLUMNS > 1) ? $clog2(COLUMNS) : 1,
  localparam int unsigned CELLS      = ROWS * COLUMNS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [31:0]            cfg_data,
  output logic                   instr_we,
  output logic [ROW_W-1:0]       instr_row,
  output logic [COL_W-1:0]       instr_col,
  output logic [ADDR_WIDTH-1:0]  instr_addr,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [CELLS-1:0]       seq_start,
  output logic                   load_done,
  output logic                   hdr_err,
  output logic                   busy
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic       bcast;
    logic [4:0] rsvd;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] start_addr;
    logic [7:0] count;
  } hdr_t;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;

  state_t                 state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]       rem_q, rem_d;

  logic                   we_d;
  logic [ROW_W-1:0]       wrow_d;
  logic [COL_W-1:0]       wcol_d;
  logic [ADDR_WIDTH-1:0]  waddr_d;
  logic [INSTR_WIDTH-1:0] wdata_d;
  logic [CELLS-1:0]       start_d;
  logic                   done_d;
  logic                   err_d;

  hdr_t                   hdr;
  logic                   xfer;
  logic                   in_range;
  logic                   span_ok;
  logic                   legal;
  logic [CELLS-1:0]       start_mask;
  logic                   unused_rsvd;

  assign hdr         = hdr_t'(cfg_data);
  assign xfer        = cfg_valid && cfg_ready;
  assign unused_rsvd = ^hdr.rsvd;

  // Header legality; the span sum is done in 9 bits so it cannot wrap.
  always_comb begin
    in_range = ({1'b0, hdr.row} < 5'(ROWS)) && ({1'b0, hdr.col} < 5'(COLUMNS));
    span_ok  = (hdr.count != 8'd0) &&
               (({1'b0, hdr.start_addr} + {1'b0, hdr.count}) <= 9'(INSTR_DEPTH));
    legal    = ((hdr.op == OP_START) && (hdr.bcast || in_range)) ||
               ((hdr.op == OP_LOAD) && in_range && span_ok);
  end

  // Start pulse pattern: single addressed cell or every cell on broadcast.
  always_comb begin
    start_mask = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLUMNS; c++) begin
        start_mask[r*COLUMNS+c] = hdr.bcast || ((hdr.row == 4'(r)) && (hdr.col == 4'(c)));
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    we_d    = 1'b0;
    wrow_d  = instr_row;
    wcol_d  = instr_col;
    waddr_d = instr_addr;
    wdata_d = instr_data;
    start_d = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (!legal) begin
            err_d = 1'b1;
          end else if (hdr.op == OP_START) begin
            start_d = start_mask;
          end else begin
            row_d   = ROW_W'(hdr.row);
            col_d   = COL_W'(hdr.col);
            addr_d  = ADDR_WIDTH'(hdr.start_addr);
            rem_d   = hdr.count;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          we_d    = 1'b1;
          wrow_d  = row_q;
          wcol_d  = col_q;
          waddr_d = addr_q;
          wdata_d = cfg_data[INSTR_WIDTH-1:0];
          addr_d  = addr_q + ADDR_WIDTH'(1);
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, packet context and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      cfg_ready  <= 1'b0;
      instr_we   <= 1'b0;
      instr_row  <= '0;
      instr_col  <= '0;
      instr_addr <= '0;
      instr_data <= '0;
      seq_start  <= '0;
      load_done  <= 1'b0;
      hdr_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      cfg_ready  <= (state_d != COMMIT);
      instr_we   <= we_d;
      instr_row  <= wrow_d;
      instr_col  <= wcol_d;
      instr_addr <= waddr_d;
      instr_data <= wdata_d;
      seq_start  <= start_d;
      load_done  <= done_d;
      hdr_err    <= err_d;
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_seq_instr_loader.sv
// Directed self-checking bench for seq_instr_loader.
module tb_seq_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_data = 32'h0;
  logic        instr_we;
  logic [0:0]  instr_row;
  logic [2:0]  instr_col;
  logic [5:0]  instr_addr;
  logic [26:0] instr_data;
  logic [15:0] seq_start;
  logic        load_done;
  logic        hdr_err;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit armed = 1'b0;

  int          w_addr[$];
  int          w_row[$];
  int          w_col[$];
  logic [31:0] w_data[$];
  int          w_cyc[$];
  int          d_cyc[$];
  logic [15:0] s_val[$];
  int          err_n = 0;
  int          rdy_low = 0;

  localparam logic [1:0] LD = 2'b01;
  localparam logic [1:0] ST = 2'b10;

  seq_instr_loader dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .instr_we(instr_we), .instr_row(instr_row), .instr_col(instr_col), .instr_addr(instr_addr),
    .instr_data(instr_data), .seq_start(seq_start), .load_done(load_done), .hdr_err(hdr_err),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output event log, sampled mid-cycle.
  always @(negedge clk) begin
    if (armed) begin
      if (instr_we === 1'b1) begin
        w_addr.push_back(int'(instr_addr));
        w_row.push_back(int'(instr_row));
        w_col.push_back(int'(instr_col));
        w_data.push_back(32'(instr_data));
        w_cyc.push_back(cyc);
      end
      if (load_done === 1'b1) d_cyc.push_back(cyc);
      if (hdr_err === 1'b1) err_n++;
      if (seq_start !== 16'h0) s_val.push_back(seq_start);
      if (!rst && cfg_ready !== 1'b1) rdy_low++;
    end
  end

  function automatic logic [31:0] hdr(input logic [1:0] op, input logic bc, input logic [3:0] r,
                                      input logic [3:0] c, input logic [7:0] sa, input logic [7:0] cnt);
    return {op, bc, 5'b0, r, c, sa, cnt};
  endfunction

  task automatic clear_log();
    w_addr.delete(); w_row.delete(); w_col.delete(); w_data.delete(); w_cyc.delete();
    d_cyc.delete(); s_val.delete(); err_n = 0; rdy_low = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] w);
    int g = 0;
    cfg_valid = 1'b1;
    cfg_data  = w;
    while (cfg_ready !== 1'b1 && g < 20) begin @(posedge clk); #1; g++; end
    checks++;
    if (g >= 20) begin failures++; $display("FAIL send_timeout got cfg_ready=%b want 1", cfg_ready); end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_data  = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({instr_we, load_done, hdr_err, busy, cfg_ready} !== 5'b0) begin
      failures++; $display("FAIL reset_strobes got %b want 00000", {instr_we, load_done, hdr_err, busy, cfg_ready});
    end
    checks++;
    if ({instr_row, instr_col, instr_addr, instr_data, seq_start} !== 53'h0) begin
      failures++; $display("FAIL reset_data got %h want 0", {instr_row, instr_col, instr_addr, instr_data, seq_start});
    end
    rst = 1'b0;
    idle(1);
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_release got ready=%b busy=%b want 1 0", cfg_ready, busy);
    end
    armed = 1'b1;
  endtask

  task automatic test_load_b2b();
    logic [31:0] exp_d[3] = '{32'h1111111, 32'h2222222, 32'h3333333};
    clear_log();
    send(hdr(LD, 1'b0, 4'd1, 4'd3, 8'd5, 8'd3));
    send(32'hF9111111);
    send(32'h02222222);
    send(32'h03333333);
    idle(4);
    checks++;
    if (w_addr.size() != 3) begin failures++; $display("FAIL b2b_count got %0d want 3", w_addr.size()); end
    for (int i = 0; i < w_addr.size() && i < 3; i++) begin
      checks++;
      if (w_addr[i] != 5 + i || w_row[i] != 1 || w_col[i] != 3 || w_data[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL b2b_write[%0d] got a=%0d r=%0d c=%0d d=%h want a=%0d r=1 c=3 d=%h",
                 i, w_addr[i], w_row[i], w_col[i], w_data[i], 5 + i, exp_d[i]);
      end
      checks++;
      if (w_cyc[i] != w_cyc[0] + i) begin
        failures++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", i, w_cyc[i], w_cyc[0] + i);
      end
    end
    checks++;
    if (d_cyc.size() != 1 || w_cyc.size() != 3 || d_cyc[0] != w_cyc[2] + 1) begin
      failures++; $display("FAIL b2b_done got %0d pulses want 1 pulse one cycle after last write", d_cyc.size());
    end
    checks++;
    if (rdy_low != 1) begin failures++; $display("FAIL b2b_ready_low got %0d cycles want 1", rdy_low); end
  endtask

  task automatic test_load_gaps();
    logic [31:0] exp_d[3] = '{32'h1111111, 32'h2222222, 32'h3333333};
    clear_log();
    send(hdr(LD, 1'b0, 4'd1, 4'd3, 8'd5, 8'd3));
    for (int i = 0; i < 3; i++) begin
      send(exp_d[i]);
      if (i < 2) begin
        for (int k = 0; k < 2; k++) begin
          @(posedge clk); #1;
          checks++;
          if (busy !== 1'b1) begin failures++; $display("FAIL gap_busy[%0d] got %b want 1", i, busy); end
        end
      end
    end
    idle(4);
    checks++;
    if (w_addr.size() != 3) begin failures++; $display("FAIL gap_count got %0d want 3", w_addr.size()); end
    for (int i = 0; i < w_addr.size() && i < 3; i++) begin
      checks++;
      if (w_addr[i] != 5 + i || w_row[i] != 1 || w_col[i] != 3 || w_data[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL gap_write[%0d] got a=%0d r=%0d c=%0d d=%h want a=%0d r=1 c=3 d=%h",
                 i, w_addr[i], w_row[i], w_col[i], w_data[i], 5 + i, exp_d[i]);
      end
      checks++;
      if (w_cyc[i] != w_cyc[0] + 3 * i) begin
        failures++; $display("FAIL gap_cycle[%0d] got %0d want %0d", i, w_cyc[i], w_cyc[0] + 3 * i);
      end
    end
    checks++;
    if (d_cyc.size() != 1 || w_cyc.size() != 3 || d_cyc[0] != w_cyc[2] + 1) begin
      failures++; $display("FAIL gap_done got %0d pulses want 1 pulse one cycle after last write", d_cyc.size());
    end
  endtask

  task automatic test_boundary();
    clear_log();
    send(hdr(LD, 1'b0, 4'd0, 4'd0, 8'd60, 8'd4));
    for (int i = 0; i < 4; i++) send(32'h100 + 32'(i));
    idle(3);
    checks++;
    if (w_addr.size() != 4 || d_cyc.size() != 1 || err_n != 0) begin
      failures++; $display("FAIL bnd_accept got writes=%0d done=%0d err=%0d want 4 1 0", w_addr.size(), d_cyc.size(), err_n);
    end
    for (int i = 0; i < w_addr.size() && i < 4; i++) begin
      checks++;
      if (w_addr[i] != 60 + i || w_data[i] !== 32'h100 + 32'(i)) begin
        failures++; $display("FAIL bnd_write[%0d] got a=%0d d=%h want a=%0d d=%h", i, w_addr[i], w_data[i], 60 + i, 32'h100 + 32'(i));
      end
    end
    clear_log();
    send(hdr(LD, 1'b0, 4'd0, 4'd0, 8'd61, 8'd4));
    idle(2);
    checks++;
    if (err_n != 1 || w_addr.size() != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL bnd_reject got err=%0d writes=%0d busy=%b want 1 0 0", err_n, w_addr.size(), busy);
    end
    send(hdr(ST, 1'b0, 4'd0, 4'd1, 8'd0, 8'd0));
    idle(2);
    checks++;
    if (s_val.size() != 1 || s_val[0] !== 16'h0002 || w_addr.size() != 0) begin
      failures++; $display("FAIL bnd_next_header got starts=%0d writes=%0d want 1 start 16'h0002, 0 writes", s_val.size(), w_addr.size());
    end
  endtask

  task automatic test_illegal();
    clear_log();
    send(hdr(2'b00, 1'b0, 4'd0, 4'd0, 8'd0, 8'd1)); idle(1);
    send(hdr(LD, 1'b0, 4'd2, 4'd0, 8'd0, 8'd1));    idle(1);
    send(hdr(LD, 1'b0, 4'd0, 4'd0, 8'd0, 8'd0));    idle(1);
    send(hdr(LD, 1'b0, 4'd0, 4'd8, 8'd0, 8'd1));    idle(1);
    send(hdr(2'b11, 1'b1, 4'd0, 4'd0, 8'd0, 8'd1)); idle(1);
    send(hdr(ST, 1'b0, 4'd2, 4'd0, 8'd0, 8'd0));    idle(2);
    checks++;
    if (err_n != 6) begin failures++; $display("FAIL illegal_err got %0d pulses want 6", err_n); end
    checks++;
    if (w_addr.size() != 0 || s_val.size() != 0 || d_cyc.size() != 0) begin
      failures++; $display("FAIL illegal_side got writes=%0d starts=%0d done=%0d want 0 0 0", w_addr.size(), s_val.size(), d_cyc.size());
    end
  endtask

  task automatic test_start();
    clear_log();
    send(hdr(ST, 1'b0, 4'd0, 4'd7, 8'd0, 8'd0)); idle(2);
    send(hdr(ST, 1'b1, 4'd15, 4'd15, 8'd0, 8'd0)); idle(2);
    send(hdr(ST, 1'b0, 4'd1, 4'd2, 8'd0, 8'd0)); idle(2);
    checks++;
    if (s_val.size() != 3) begin failures++; $display("FAIL start_count got %0d want 3", s_val.size()); end
    checks++;
    if (s_val.size() < 3 || s_val[0] !== 16'h0080 || s_val[1] !== 16'hFFFF || s_val[2] !== 16'h0400) begin
      failures++; $display("FAIL start_value got %p want 0080 ffff 0400", s_val);
    end
    checks++;
    if (err_n != 0 || busy !== 1'b0) begin failures++; $display("FAIL start_side got err=%0d busy=%b want 0 0", err_n, busy); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    send(hdr(LD, 1'b0, 4'd1, 4'd2, 8'd10, 8'd4));
    send(32'hAAA);
    send(32'hBBB);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || instr_we !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_state got busy=%b we=%b ready=%b want 0 0 0", busy, instr_we, cfg_ready);
    end
    rst = 1'b0;
    idle(3);
    checks++;
    if (w_addr.size() != 2 || d_cyc.size() != 0) begin
      failures++; $display("FAIL rstmid_abort got writes=%0d done=%0d want 2 0", w_addr.size(), d_cyc.size());
    end
    checks++;
    if (w_addr.size() < 2 || w_addr[0] != 10 || w_addr[1] != 11 || w_data[1] !== 32'hBBB) begin
      failures++; $display("FAIL rstmid_writes got %p want addrs 10 11", w_addr);
    end
    clear_log();
    send(hdr(LD, 1'b0, 4'd0, 4'd5, 8'd0, 8'd2));
    send(32'h7FFFFFF);
    send(32'h0000001);
    idle(3);
    checks++;
    if (w_addr.size() != 2 || d_cyc.size() != 1) begin
      failures++; $display("FAIL rstmid_after got writes=%0d done=%0d want 2 1", w_addr.size(), d_cyc.size());
    end
    checks++;
    if (w_addr.size() < 2 || w_addr[0] != 0 || w_addr[1] != 1 || w_row[1] != 0 || w_col[1] != 5 ||
        w_data[0] !== 32'h7FFFFFF || w_data[1] !== 32'h1) begin
      failures++; $display("FAIL rstmid_after_data got addrs=%p data=%p want 0 1 / 7ffffff 1", w_addr, w_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_b2b();
    test_load_gaps();
    test_boundary();
    test_illegal();
    test_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_instr_loader.md
Name: seq_instr_loader

Overview:
- Configuration-side writer for the per-cell sequencer instruction memories of the DRRA fabric.
- Accepts a 32-bit word stream (valid/ready): a header word, then instruction words.
- Writes the instruction words into the addressed cell's instruction memory and issues per-cell sequencer start pulses.
- Sits between the configuration bus and the ROWS x COLUMNS sequencers. It is the producer of the instruction memory contents that the sequencers later fetch and execute (REFI, DPU, SWB, WAIT, LOOP, ...).

Parameters:
- ROWS, 2, fabric rows.
- COLUMNS, 8, fabric columns.
- INSTR_WIDTH, 27, sequencer instruction width in bits; must be <= 32.
- INSTR_DEPTH, 64, instruction memory depth per cell; must be <= 256.
- ADDR_WIDTH, 6, instruction memory address width; equals clog2(INSTR_DEPTH).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- cfg_valid  in  1  input word valid.
- cfg_ready  out  1  loader accepts word.
- cfg_data  in  32  header or instruction word.
- instr_we  out  1  instruction memory write strobe.
- instr_row  out  clog2(ROWS)  target row.
- instr_col  out  clog2(COLUMNS)  target column.
- instr_addr  out  ADDR_WIDTH  write address.
- instr_data  out  INSTR_WIDTH  instruction word, equal to cfg_data[INSTR_WIDTH-1:0].
- seq_start  out  ROWS*COLUMNS  one-cycle start pulses; bit index = row*COLUMNS+col.
- load_done  out  1  one-cycle pulse, packet fully written.
- hdr_err  out  1  one-cycle pulse, illegal header dropped.
- busy  out  1  high when state != IDLE.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Header fields:
  - [31:30] op: 01 = LOAD, 10 = START, 00/11 illegal.
  - [29] bcast (START only).
  - [28:24] reserved, ignored.
  - [23:20] row; [19:16] col; [15:8] start_addr; [7:0] count.
- Header legality:
  - op legal.
  - For a non-broadcast header: row < ROWS and col < COLUMNS.
  - For LOAD: count >= 1 and start_addr + count <= INSTR_DEPTH, evaluated in 9-bit arithmetic (no wrap).
- A word is transferred when cfg_valid && cfg_ready.
- FSM:
  - IDLE: cfg_ready = 1.
    - Transferred illegal header: hdr_err pulses next cycle, stay IDLE, word discarded.
    - Legal START: next cycle, seq_start has bit row*COLUMNS+col set (all bits if bcast); stay IDLE.
    - Legal LOAD: latch row, col, addr = start_addr, remaining = count; go to LOAD.
  - LOAD: cfg_ready = 1.
    - Each transferred word: next cycle instr_we = 1 with latched row/col, current addr, and data; then addr++, remaining--.
    - On the transfer where remaining == 1, go to COMMIT.
    - Gaps (cfg_valid = 0) are allowed: instr_we stays 0 and the FSM waits.
  - COMMIT: cfg_ready = 0 for exactly one cycle; load_done = 1 (one cycle after the last instr_we); go to IDLE.
- Latency: every output strobe appears 1 cycle after the accepting handshake. Throughput is 1 word/cycle, plus one bubble cycle per LOAD packet.
- Address never wraps: guaranteed by the legality check; the final write address is start_addr + count - 1.
- Instruction words are never interpreted as headers while in LOAD.
- cfg_data[31:INSTR_WIDTH] of instruction words is ignored.
- cfg_ready does not depend on cfg_valid (no combinational loop).
- Reset asserted mid-LOAD: packet aborted; no further instr_we; no load_done; state IDLE on the next cycle.
- seq_start, load_done and hdr_err are never asserted for more than one cycle per event.

Test Plan:
- LOAD to row 1, col 3, start_addr 5, count 3, words 0x1111111/0x2222222/0x3333333 back-to-back:
  - instr_we for 3 cycles, addr 5, 6, 7, row 1, col 3, matching data.
  - load_done exactly 1 cycle after the last write.
  - cfg_ready low for 1 cycle.
- Same LOAD with cfg_valid deasserted 2 cycles between words: identical writes, no spurious instr_we, busy held high throughout.
- Boundary: start_addr 60, count 4 is accepted (addr 60..63). Start_addr 61, count 4 → hdr_err pulse, no writes, stays IDLE, and the next word is treated as a header.
- Illegal headers: op 00, row 2, count 0 → one hdr_err pulse each, instr_we never asserted.
- START row 0, col 7 → seq_start = 16'h0080 for one cycle. START with bcast → seq_start = 16'hFFFF for one cycle.
- rst asserted after the 2nd of 4 LOAD words → only 2 writes observed, no load_done. A subsequent LOAD completes normally.
